// File: rtl/adc_pipe_pkg.sv
// rtl/adc_pipe_pkg.sv - shared one-hot decision codes and residue saturation helper
package adc_pipe_pkg;

  localparam logic [2:0] OH_NEG  = 3'b001;
  localparam logic [2:0] OH_ZERO = 3'b010;
  localparam logic [2:0] OH_POS  = 3'b100;

  // Clamp a residue to the stage output range [-vref, vref-1].
  function automatic int sat_residue(input int r, input int vref);
    if (r > vref - 1) begin
      return vref - 1;
    end else if (r < -vref) begin
      return -vref;
    end
    return r;
  endfunction

endpackage

// File: rtl/adc_pipe_stage_model.sv
// rtl/adc_pipe_stage_model.sv - one 1.5-bit stage: compare, one-hot decision, residue, register
module adc_pipe_stage_model
  import adc_pipe_pkg::*;
#(
  parameter int SAMPLE_BITS = 6,
  parameter int OFFS_BITS   = 3
) (
  input  logic                         clock_i,
  input  logic                         reset_i,
  input  logic                         en_i,
  input  logic signed [SAMPLE_BITS+1:0] r_i,
  input  logic                         v_i,
  input  logic        [OFFS_BITS-1:0]  offs_i,
  output logic        [2:0]            d_o,
  output logic                         v_o,
  output logic signed [SAMPLE_BITS+1:0] r_o
);

  localparam int RW   = SAMPLE_BITS + 2;
  localparam int VREF = 1 << (SAMPLE_BITS - 1);
  localparam int THR  = 1 << (SAMPLE_BITS - 3);

  logic signed [RW-1:0] offs_ext;
  logic signed [RW-1:0] thr_hi;
  logic signed [RW-1:0] thr_lo;
  logic signed [RW-1:0] two_r;
  logic signed [RW-1:0] raw;
  logic        [2:0]    d_d, d_q;
  logic                 v_q;
  logic signed [RW-1:0] r_d, r_q;

  always_comb begin
    offs_ext = {{(RW - OFFS_BITS){offs_i[OFFS_BITS-1]}}, offs_i};
    thr_hi   = RW'(THR) + offs_ext;
    thr_lo   = -thr_hi;
    two_r    = r_i <<< 1;
    d_d      = OH_ZERO;
    raw      = two_r;
    if (r_i > thr_hi) begin
      d_d = OH_POS;
      raw = two_r - RW'(VREF);
    end else if (r_i < thr_lo) begin
      d_d = OH_NEG;
      raw = two_r + RW'(VREF);
    end
    r_d = RW'(sat_residue(int'(raw), VREF));
    // Bubbles carry a neutral decision and zero residue down the chain.
    if (!v_i) begin
      d_d = OH_ZERO;
      r_d = '0;
    end
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      d_q <= OH_ZERO;
      v_q <= 1'b0;
      r_q <= '0;
    end else if (en_i) begin
      d_q <= d_d;
      v_q <= v_i;
      r_q <= r_d;
    end
  end

  assign d_o = d_q;
  assign v_o = v_q;
  assign r_o = r_q;

endmodule

// File: rtl/adc_pipe_stage_emulator.sv
// rtl/adc_pipe_stage_emulator.sv - 3-stage 1.5-bit pipelined ADC front-end emulator top
module adc_pipe_stage_emulator
  import adc_pipe_pkg::*;
#(
  parameter int SAMPLE_BITS = 6,
  parameter int OFFS_BITS   = 3
) (
  input  logic                   clock_i,
  input  logic                   reset_i,
  input  logic [SAMPLE_BITS-1:0] sample_i,
  input  logic                   valid_i,
  output logic                   ready_o,
  input  logic                   freeze_i,
  input  logic [OFFS_BITS-1:0]   offs1_i,
  input  logic [OFFS_BITS-1:0]   offs2_i,
  input  logic [OFFS_BITS-1:0]   offs3_i,
  output logic [2:0]             d1_o,
  output logic [2:0]             d2_o,
  output logic [2:0]             d3_o,
  output logic                   v1_o,
  output logic                   v2_o,
  output logic                   v3_o,
  output logic [SAMPLE_BITS-1:0] res_o
);

  localparam int RW   = SAMPLE_BITS + 2;
  localparam int VREF = 1 << (SAMPLE_BITS - 1);

  logic                 accept;
  logic                 stage_en;
  logic signed [RW-1:0] r1, r2, r3, r4;
  logic                 v1, v2;
  logic                 unused_res_hi;

  assign ready_o  = ~freeze_i;
  assign stage_en = ~freeze_i;
  assign accept   = valid_i & ready_o;
  assign r1       = $signed({2'b00, sample_i}) - RW'(VREF);

  adc_pipe_stage_model #(.SAMPLE_BITS(SAMPLE_BITS), .OFFS_BITS(OFFS_BITS)) u_stage1 (
    .clock_i(clock_i), .reset_i(reset_i), .en_i(stage_en),
    .r_i(r1), .v_i(accept), .offs_i(offs1_i),
    .d_o(d1_o), .v_o(v1), .r_o(r2)
  );

  adc_pipe_stage_model #(.SAMPLE_BITS(SAMPLE_BITS), .OFFS_BITS(OFFS_BITS)) u_stage2 (
    .clock_i(clock_i), .reset_i(reset_i), .en_i(stage_en),
    .r_i(r2), .v_i(v1), .offs_i(offs2_i),
    .d_o(d2_o), .v_o(v2), .r_o(r3)
  );

  adc_pipe_stage_model #(.SAMPLE_BITS(SAMPLE_BITS), .OFFS_BITS(OFFS_BITS)) u_stage3 (
    .clock_i(clock_i), .reset_i(reset_i), .en_i(stage_en),
    .r_i(r3), .v_i(v2), .offs_i(offs3_i),
    .d_o(d3_o), .v_o(v3_o), .r_o(r4)
  );

  assign v1_o = v1;
  assign v2_o = v2;
  // Saturated residue always fits in SAMPLE_BITS signed; the guard bits are redundant.
  assign res_o         = r4[SAMPLE_BITS-1:0];
  assign unused_res_hi = ^r4[RW-1:SAMPLE_BITS];

endmodule

// File: tb/tb_adc_pipe_stage_emulator.sv
// tb/tb_adc_pipe_stage_emulator.sv - self-checking bench for adc_pipe_stage_emulator
module tb_adc_pipe_stage_emulator;

  typedef struct {
    int s;
    int o1, o2, o3;
    int e1, e2, e3;
    int er;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_i = 1'b1;
  logic [5:0] sample_i = '0;
  logic       valid_i = 1'b0;
  logic       ready_o;
  logic       freeze_i = 1'b0;
  logic [2:0] offs1_i = '0, offs2_i = '0, offs3_i = '0;
  logic [2:0] d1_o, d2_o, d3_o;
  logic       v1_o, v2_o, v3_o;
  logic [5:0] res_o;

  int n_pass = 0;
  int n_total = 0;
  logic adv = 1'b0;
  vec_t q1[$], q2[$], q3[$];
  vec_t mon_e;
  vec_t vecs[8];
  vec_t dummy;

  always #5 clk = ~clk;

  adc_pipe_stage_emulator #(.SAMPLE_BITS(6), .OFFS_BITS(3)) dut (
    .clock_i(clk), .reset_i(reset_i), .sample_i(sample_i), .valid_i(valid_i),
    .ready_o(ready_o), .freeze_i(freeze_i),
    .offs1_i(offs1_i), .offs2_i(offs2_i), .offs3_i(offs3_i),
    .d1_o(d1_o), .d2_o(d2_o), .d3_o(d3_o),
    .v1_o(v1_o), .v2_o(v2_o), .v3_o(v3_o), .res_o(res_o)
  );

  task automatic chk(input string name, input int got, input int exp);
    n_total++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, got, exp);
  endtask

  function automatic vec_t model(input int x);
    vec_t e;
    int r, d;
    int oh[3];
    r = x - 32;
    for (int k = 0; k < 3; k++) begin
      if (r > 8) d = 1;
      else if (r < -8) d = -1;
      else d = 0;
      oh[k] = (d > 0) ? 4 : ((d < 0) ? 1 : 2);
      r = 2 * r - 32 * d;
      if (r > 31) r = 31;
      if (r < -32) r = -32;
    end
    e.s = x; e.o1 = 0; e.o2 = 0; e.o3 = 0;
    e.e1 = oh[0]; e.e2 = oh[1]; e.e3 = oh[2]; e.er = r;
    return e;
  endfunction

  task automatic step(input logic v, input int s, input logic f, input logic r, input vec_t e);
    valid_i  = v;
    sample_i = s[5:0];
    freeze_i = f;
    reset_i  = r;
    if (v && !f && !r) q1.push_back(e);
    @(posedge clk);
    #1;
  endtask

  always @(posedge clk) adv <= !freeze_i && !reset_i;

  // Scoreboard: each stage's expectation moves to the next queue as it is checked.
  always @(negedge clk) begin
    if (adv) begin
      if (v3_o) begin
        if (q3.size() == 0) chk("v3_spurious", int'(v3_o), 0);
        else begin
          mon_e = q3.pop_front();
          chk($sformatf("d3[x=%0d]", mon_e.s), int'(d3_o), mon_e.e3);
          chk($sformatf("res[x=%0d]", mon_e.s), int'($signed(res_o)), mon_e.er);
        end
      end
      if (v2_o) begin
        if (q2.size() == 0) chk("v2_spurious", int'(v2_o), 0);
        else begin
          mon_e = q2.pop_front();
          chk($sformatf("d2[x=%0d]", mon_e.s), int'(d2_o), mon_e.e2);
          q3.push_back(mon_e);
        end
      end
      if (v1_o) begin
        if (q1.size() == 0) chk("v1_spurious", int'(v1_o), 0);
        else begin
          mon_e = q1.pop_front();
          chk($sformatf("d1[x=%0d]", mon_e.s), int'(d1_o), mon_e.e1);
          q2.push_back(mon_e);
        end
      end
    end
  end

  initial begin
    int run, maxrun;
    dummy = '{0, 0, 0, 0, 2, 2, 2, 0};
    vecs[0] = '{63, 0, 0, 0, 4, 4, 4, 24};
    vecs[1] = '{0,  0, 0, 0, 1, 1, 1, -32};
    vecs[2] = '{32, 0, 0, 0, 2, 2, 2, 0};
    vecs[3] = '{40, 0, 0, 0, 2, 4, 2, 0};
    vecs[4] = '{41, 0, 0, 0, 4, 1, 2, 8};
    vecs[5] = '{41, 3, 0, 0, 2, 4, 2, 8};
    vecs[6] = '{24, 0, 0, 0, 2, 1, 2, 0};
    vecs[7] = '{24, -1, 0, 0, 1, 4, 2, 0};

    step(0, 0, 0, 1, dummy);
    step(0, 0, 0, 1, dummy);
    chk("reset_ready", int'(ready_o), 1);
    chk("reset_d1", int'(d1_o), 2);
    chk("reset_d2", int'(d2_o), 2);
    chk("reset_d3", int'(d3_o), 2);
    chk("reset_v", int'({v1_o, v2_o, v3_o}), 0);
    chk("reset_res", int'(res_o), 0);
    step(0, 0, 0, 0, dummy);

    foreach (vecs[i]) begin
      offs1_i = vecs[i].o1[2:0];
      offs2_i = vecs[i].o2[2:0];
      offs3_i = vecs[i].o3[2:0];
      step(1, vecs[i].s, 0, 0, vecs[i]);
      for (int k = 0; k < 4; k++) step(0, 0, 0, 0, dummy);
    end
    offs1_i = '0; offs2_i = '0; offs3_i = '0;

    step(1, 63, 0, 0, vecs[0]);
    step(1, 0, 0, 0, vecs[1]);
    step(1, 32, 0, 0, vecs[2]);
    run = 0; maxrun = 0;
    for (int k = 0; k < 6; k++) begin
      if (v3_o) begin
        run++;
        if (run > maxrun) maxrun = run;
      end else run = 0;
      step(0, 0, 0, 0, dummy);
    end
    chk("b2b_v3_run", maxrun, 3);

    for (int k = 0; k < 20; k++) begin
      int x;
      x = $urandom_range(0, 63);
      step(1, x, 0, 0, model(x));
    end
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, dummy);

    step(1, 63, 0, 0, vecs[0]);
    step(1, 0, 0, 0, vecs[1]);
    for (int k = 0; k < 2; k++) begin
      step(1, 32, 1, 0, dummy);
      chk("frz_ready", int'(ready_o), 0);
      chk("frz_d1", int'(d1_o), 1);
      chk("frz_v1", int'(v1_o), 1);
      chk("frz_d2", int'(d2_o), 4);
      chk("frz_v2", int'(v2_o), 1);
      chk("frz_v3", int'(v3_o), 0);
    end
    step(0, 0, 0, 1, dummy);
    q1.delete(); q2.delete(); q3.delete();
    chk("rst_v", int'({v1_o, v2_o, v3_o}), 0);
    chk("rst_d", int'({d1_o, d2_o, d3_o}), 9'b010010010);
    chk("rst_res", int'(res_o), 0);
    step(1, 41, 0, 0, vecs[4]);
    chk("post_rst_v1", int'(v1_o), 1);
    for (int k = 0; k < 4; k++) step(0, 0, 0, 0, dummy);

    chk("sb_drained", q1.size() + q2.size() + q3.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
